// File: rtl/viterbi_pkg.sv
// Purpose: shared types, default thresholds and helpers for the Viterbi decoder blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package viterbi_pkg;

  // Sync monitor FSM encoding.
  typedef enum logic [1:0] {
    ST_IN_SYNC = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RECOVER = 2'd2
  } sync_state_e;

  // Default thresholds tuned for the (2,1,3) code.
  localparam int unsigned DEF_STAGE_MIN  = 3;
  localparam int unsigned DEF_METRIC_THR = 8;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sync_window_counter.sv
// Purpose: counts qualifying samples and violations per window; flags the window end and a bad window end.
// Latency: win_end_o/bad_end_o are combinational on the closing sample; counters update next clock.
// Backpressure: none; every sample is accepted, en_i low holds both counters at zero.
module sync_window_counter #(
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned HIT_THR = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic q_i,
  input  logic v_i,
  input  logic clear_i,
  output logic win_end_o,
  output logic bad_end_o
);
  import viterbi_pkg::*;

  localparam int CW = $clog2(WIN_LEN + 1);
  localparam int SW = CW + 1;

  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] hit_cnt_q, hit_cnt_d;
  logic [SW-1:0] hit_sum;

  // The closing sample's own violation counts toward the window verdict.
  assign win_end_o = en_i && q_i && (win_cnt_q == CW'(WIN_LEN - 1));
  assign hit_sum   = {1'b0, hit_cnt_q} + SW'(v_i);
  assign bad_end_o = win_end_o && (hit_sum >= SW'(HIT_THR));

  // Next-state: clear/disable/window end zero both counters, otherwise count samples and hits.
  always_comb begin
    win_cnt_d = win_cnt_q;
    hit_cnt_d = hit_cnt_q;
    if (clear_i || !en_i || win_end_o) begin
      win_cnt_d = '0;
      hit_cnt_d = '0;
    end else if (q_i) begin
      win_cnt_d = win_cnt_q + CW'(1);
      if (v_i) begin
        hit_cnt_d = CW'(sat_inc(32'(hit_cnt_q), 32'(WIN_LEN)));
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

endmodule

// File: rtl/viterbi_sync_monitor.sv
// Purpose: out-of-sync monitor for the path-metric stage: windowed violation check, hold-off/recovery FSM, loss counter.
// Latency: error_o, in_sync_o and resync_req_o are registered, one clock after the deciding sample.
// Backpressure: none; samples are observed only, never stalled.
module viterbi_sync_monitor #(
  parameter int unsigned STAGE_W    = 4,
  parameter int unsigned METRIC_W   = 4,
  parameter int unsigned STAGE_MIN  = viterbi_pkg::DEF_STAGE_MIN,
  parameter int unsigned METRIC_THR = viterbi_pkg::DEF_METRIC_THR,
  parameter int unsigned WIN_LEN    = 16,
  parameter int unsigned HIT_THR    = 4,
  parameter int unsigned HOLD_LEN   = 8,
  parameter int unsigned CLEAN_LEN  = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [STAGE_W-1:0]  stage_i,
  input  logic [METRIC_W-1:0] metric_i,
  input  logic                clear_i,
  output logic                error_o,
  output logic                in_sync_o,
  output logic                resync_req_o,
  output logic [CNT_W-1:0]    loss_count_o
);
  import viterbi_pkg::*;

  localparam int HW = $clog2(HOLD_LEN + 1);
  localparam int LW = $clog2(CLEAN_LEN + 1);
  localparam logic [31:0] LOSS_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                   : 32'((64'd1 << CNT_W) - 64'd1);

  sync_state_e   state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [LW-1:0] clean_cnt_q, clean_cnt_d;
  logic [CNT_W-1:0] loss_count_q, loss_count_d;
  logic          resync_q, resync_d;
  logic          error_q;
  logic          loss_inc;
  logic          q_smp, v_smp;
  logic          win_en, bad_end;

  // Sample classification, unsigned at full port width.
  assign q_smp  = we_i && (stage_i >= STAGE_W'(STAGE_MIN));
  assign v_smp  = q_smp && (metric_i > METRIC_W'(METRIC_THR));
  assign win_en = (state_q != ST_HOLD);

  sync_window_counter #(
    .WIN_LEN (WIN_LEN),
    .HIT_THR (HIT_THR)
  ) u_win (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (win_en),
    .q_i       (q_smp),
    .v_i       (v_smp),
    .clear_i   (clear_i),
    .win_end_o (),
    .bad_end_o (bad_end)
  );

  // FSM next-state: bad window end always wins, hold counts clocks, recovery counts clean samples.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    clean_cnt_d = clean_cnt_q;
    resync_d    = 1'b0;
    loss_inc    = 1'b0;
    case (state_q)
      ST_IN_SYNC: begin
        if (bad_end) begin
          state_d     = ST_HOLD;
          resync_d    = 1'b1;
          loss_inc    = 1'b1;
          hold_cnt_d  = '0;
          clean_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        clean_cnt_d = '0;
        if (hold_cnt_q == HW'(HOLD_LEN - 1)) begin
          state_d    = ST_RECOVER;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RECOVER: begin
        if (bad_end) begin
          state_d     = ST_HOLD;
          resync_d    = 1'b1;
          hold_cnt_d  = '0;
          clean_cnt_d = '0;
        end else if (v_smp) begin
          clean_cnt_d = '0;
        end else if (q_smp) begin
          if (clean_cnt_q == LW'(CLEAN_LEN - 1)) begin
            state_d     = ST_IN_SYNC;
            clean_cnt_d = '0;
          end else begin
            clean_cnt_d = clean_cnt_q + LW'(1);
          end
        end
      end
      default: begin
        state_d     = ST_IN_SYNC;
        hold_cnt_d  = '0;
        clean_cnt_d = '0;
      end
    endcase
  end

  // Loss counter: clear beats a simultaneous increment; increment saturates.
  always_comb begin
    loss_count_d = loss_count_q;
    if (clear_i) begin
      loss_count_d = '0;
    end else if (loss_inc) begin
      loss_count_d = CNT_W'(sat_inc(32'(loss_count_q), LOSS_MAX));
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IN_SYNC;
      hold_cnt_q   <= '0;
      clean_cnt_q  <= '0;
      loss_count_q <= '0;
      resync_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      clean_cnt_q  <= clean_cnt_d;
      loss_count_q <= loss_count_d;
      resync_q     <= resync_d;
      error_q      <= v_smp;
    end
  end

  assign error_o      = error_q;
  assign in_sync_o    = (state_q == ST_IN_SYNC);
  assign resync_req_o = resync_q;
  assign loss_count_o = loss_count_q;

endmodule

// File: doc/viterbi_sync_monitor.md
Name: viterbi_sync_monitor

Overview:
- Parametrised out-of-synchronisation monitor for the Viterbi decoder path-metric stage. It generalises the single-sample sync-error flag in four ways:
  - configurable stage and metric widths and thresholds;
  - windowed violation counting;
  - a recovery state machine with hold-off and hysteresis;
  - a saturating loss-of-sync event counter.
- Sits beside the decoder's survivor-memory write port. Its resync request drives the deinterleaver/branch-alignment controller.

Parameters:
- STAGE_W, 4, width of stage input.
- METRIC_W, 4, width of metric input.
- STAGE_MIN, 3, minimum stage index at which samples qualify.
- METRIC_THR, 8, a metric strictly greater than this is a violation.
- WIN_LEN, 16, qualifying samples per evaluation window (≥2).
- HIT_THR, 4, violations per window that make the window bad (1..WIN_LEN).
- HOLD_LEN, 8, clocks of hold-off after a resync request (≥1).
- CLEAN_LEN, 32, consecutive clean qualifying samples needed to declare sync (≥1).
- CNT_W, 16, width of loss_count.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- we, input, 1, survivor write enable; the sample is valid when high.
- stage, input, STAGE_W, current trellis stage index.
- metric, input, METRIC_W, normalised best path metric for this stage.
- clear, input, 1, synchronous clear of loss_count and the window/hit counters.
- error, output, 1, registered per-sample violation flag.
- in_sync, output, 1, high when FSM is in IN_SYNC.
- resync_req, output, 1, one-clock pulse requesting realignment.
- loss_count, output, CNT_W, saturating count of IN_SYNC→HOLD transitions.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - error=0, in_sync=1, resync_req=0, loss_count=0;
  - all internal counters 0;
  - FSM=IN_SYNC.
- Reset mid-operation aborts any window, hold or recovery immediately.
- Sample classification:
  - qualifying (q) = we && stage ≥ STAGE_MIN (unsigned);
  - violation (v) = q && metric > METRIC_THR.
  - All comparisons are unsigned at full input width; the thresholds are sized to the port widths.
- error: registered v, with one clock latency. It is computed in every FSM state, including HOLD.
- Window logic (active in IN_SYNC and RECOVER):
  - win_cnt increments on each q.
  - hit_cnt increments on each v, saturating at WIN_LEN.
  - The window ends on the q that brings win_cnt to WIN_LEN.
  - That sample's own violation is included, so bad = (hit_cnt + v) ≥ HIT_THR.
  - Both counters return to 0 on that clock.
- FSM states: IN_SYNC, HOLD, RECOVER.
  - IN_SYNC → HOLD on a bad window end. Same clock: resync_req pulses (registered, high the next cycle), loss_count increments, saturating at 2^CNT_W−1.
  - HOLD: q samples are ignored; win_cnt, hit_cnt and clean_cnt are held at 0. hold_cnt counts clocks. After HOLD_LEN clocks in HOLD, go to RECOVER.
  - RECOVER, clean count: clean_cnt increments on each q with !v and resets to 0 on v. When the increment reaches CLEAN_LEN, go to IN_SYNC.
  - RECOVER, bad window end: go to HOLD and pulse resync_req again. loss_count does not change.
  - RECOVER, bad-window priority: if a bad window end and clean completion happen on the same sample, the bad window wins (HOLD).
- in_sync = (state == IN_SYNC), registered with the state.
- clear:
  - zeroes loss_count, win_cnt and hit_cnt next clock;
  - does not alter the FSM, hold_cnt or clean_cnt;
  - takes priority over a simultaneous increment of those registers.
- If clear coincides with a bad window end, the transition and resync_req still occur. loss_count reads 0 afterwards (clear wins).
- we low, or stage < STAGE_MIN, makes the sample invisible to all counters.

Decomposition:
- Shared package (viterbi_pkg):
  - FSM state encoding;
  - default threshold constants for the (2,1,3) code: STAGE_MIN=3, METRIC_THR=8;
  - a saturating-increment function reused by other decoder blocks.
- One natural sub-module, sync_window_counter: win_cnt/hit_cnt with a bad-window-end output, parametrised by WIN_LEN/HIT_THR, with a synchronous clear.

Test Plan:
- Reset mid-recovery: drive into RECOVER, assert reset low → outputs immediately in_sync=1, error=0, loss_count=0, resync_req=0 with no clock edge.
- Per-sample flag:
  - we=1, stage=3, metric=9 → error=1 one clock later;
  - metric=8, or stage=2 → error=0;
  - we=0 → error=0.
- Window threshold:
  - 16 qualifying samples, exactly 4 with metric=9 (the last being one) → resync_req single pulse, in_sync=0, loss_count=1;
  - repeat with 3 violations → no pulse, in_sync stays 1.
- Hold and recovery:
  - after loss, violations during the 8 HOLD clocks are ignored;
  - then 31 clean samples, one violation, then 32 clean samples → in_sync returns to 1 exactly on the 32nd clean sample after the violation;
  - loss_count stays 1.
- Re-loss in RECOVER: bad window while recovering → second resync_req pulse, FSM back to HOLD, loss_count unchanged at 1.
- Saturation and clear:
  - CNT_W=2, force 5 loss events → loss_count=3;
  - assert clear on the same clock as a bad window end → loss_count=0 next cycle, resync_req still pulses.
